// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// registered slices of WIDTH/STAGES bits, with valid/ready flow control on both sides.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = WIDTH / STAGES;

   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];

   logic [WIDTH-1:0] a_in [STAGES];
   logic [WIDTH-1:0] b_in [STAGES];
   logic [WIDTH-1:0] s_in [STAGES];
   logic [WIDTH-1:0] s_nx [STAGES];
   logic             c_in [STAGES];
   logic             c_nx [STAGES];
   logic             v_in [STAGES];
   logic [CW:0]      slice [STAGES];

   logic adv;
   logic ovf_q, zero_q;
   logic ovf_nx, zero_nx;

   // One global enable: the whole pipe moves or the whole pipe holds.
   assign adv      = ~v_q[STAGES-1] | out_ready;
   assign in_ready = adv;

   always_comb begin
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in[0] = sub | cin;
      s_in[0] = '0;
      v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
         s_in[k] = s_q[k-1];
         v_in[k] = v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
                  + {{CW{1'b0}}, c_in[k]};
         s_nx[k]  = s_in[k];
         s_nx[k][k*CW +: CW] = slice[k][CW-1:0];
         c_nx[k]  = slice[k][CW];
      end
      ovf_nx  = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
              & (s_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
      zero_nx = ~|s_nx[STAGES-1];
   end

   // Data registers only load behind a valid token, so outputs keep the last result across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_in[k];
            if (v_in[k]) begin
               a_q[k] <= a_in[k];
               b_q[k] <= b_in[k];
               s_q[k] <= s_nx[k];
               c_q[k] <= c_nx[k];
            end
         end
         if (v_in[STAGES-1]) begin
            ovf_q  <= ovf_nx;
            zero_q <= zero_nx;
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed flag cases, backpressure, mid-flight reset and
// a randomized sweep over three extra parameterisations against a plain-arithmetic model.
module tb_pipelined_addsub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Main instance: WIDTH=32, STAGES=4
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
   logic [31:0] a, b, sum;

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

   // Sweep instances share one stimulus stream, truncated to each width
   logic        sw_valid, sw_cin, sw_sub;
   logic [63:0] sw_a, sw_b;
   logic        r81, v81, c81, o81, z81;
   logic        r88, v88, c88, o88, z88;
   logic        r64, v64, c64, o64, z64;
   logic [7:0]  s81, s88;
   logic [63:0] s64;

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_8_1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r81),
      .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v81),
      .out_ready(1'b1), .sum(s81), .cout(c81), .ovf(o81), .zero(z81));

   pipelined_addsub #(.WIDTH(8), .STAGES(8)) dut_8_8 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r88),
      .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v88),
      .out_ready(1'b1), .sum(s88), .cout(c88), .ovf(o88), .zero(z88));

   pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut_64_4 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(v64),
      .out_ready(1'b1), .sum(s64), .cout(c64), .ovf(o64), .zero(z64));

   // Reference: returns {zero, ovf, cout, sum zero-extended to 64 bits}
   function automatic logic [66:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic c_in, input logic do_sub);
      logic [63:0] mask, xm, ym, s;
      logic [64:0] full;
      logic        c, o;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      xm = x & mask;
      ym = y & mask;
      if (do_sub) begin
         s = (xm - ym) & mask;
         c = (xm >= ym);
         o = (xm[w-1] != ym[w-1]) && (s[w-1] != xm[w-1]);
      end else begin
         full = {1'b0, xm} + {1'b0, ym} + {64'd0, c_in};
         s = full[63:0] & mask;
         c = full[w];
         o = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
      end
      return {(s == 64'd0), o, c, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b sum=%h c=%b o=%b z=%b want all 0",
                  out_valid, sum, cout, ovf, zero);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   // Accept one operand set and check it appears exactly after edge n+3 with the given flags.
   task automatic run_one(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic ts, input logic [31:0] esum,
                          input logic ec, input logic eo, input logic ez);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
      end
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: got out_valid=%b want 0 at edge +%0d", name, out_valid, i + 1);
         end
      end
      step();
      checks++;
      if ({out_valid, sum, cout, ovf, zero} !== {1'b1, esum, ec, eo, ez}) begin
         errors++;
         $display("FAIL %s: got valid=%b sum=%h c=%b o=%b z=%b want valid=1 sum=%h c=%b o=%b z=%b",
                  name, out_valid, sum, cout, ovf, zero, esum, ec, eo, ez);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: got out_valid=%b want 0", name, out_valid);
      end
   endtask

   task automatic test_add_sub_flags();
      run_one("add_defaults", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      run_one("sub_zero",     32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
      run_one("sub_borrow",   32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_one("sub_cin_ign",  32'h5,         32'h7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_one("add_ovf",      32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_one("add_wrap",     32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
      run_one("sub_ovf",      32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [66:0] q[$];
      logic [66:0] e;
      int sent = 0, got = 0;
      bit  need_new = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = !(cyc >= 6 && cyc <= 9);
         if (sent < 10 && need_new) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            need_new = 1'b0;
         end
         in_valid = (sent < 10);
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_in_ready: cyc %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_output: cyc %0d got sum=%h want no output", cyc, sum);
            end else begin
               e = q.pop_front();
               got++;
               if ({zero, ovf, cout, 32'd0, sum} !== e) begin
                  errors++;
                  $display("FAIL bp_result%0d: got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                           got, sum, cout, ovf, zero, e[31:0], e[64], e[65], e[66]);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(32, {32'd0, a}, {32'd0, b}, cin, sub));
            sent++;
            need_new = 1'b1;
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 10 || q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d results with %0d pending want 10 and 0", got, q.size());
      end
   endtask

   task automatic test_reset_midflight();
      logic [66:0] e;
      logic [31:0] ta, tb_;
      logic        tc, ts;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre_valid: got %b want 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0) begin
         errors++;
         $display("FAIL mid_async_drop: got valid=%b sum=%h want 0 and 0", out_valid, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: got out_valid=%b want 0 at cycle %0d", out_valid, i);
         end
      end
      ta = $urandom; tb_ = $urandom; tc = 1'($urandom); ts = 1'($urandom);
      e = model(32, {32'd0, ta}, {32'd0, tb_}, tc, ts);
      run_one("mid_first_after", ta, tb_, tc, ts, e[31:0], e[64], e[65], e[66]);
   endtask

   task automatic test_param_sweep();
      logic [66:0] q81[$], q88[$], q64[$];
      int          t81[$], t88[$], t64[$];
      logic [66:0] e;
      int          t, n81 = 0, n88 = 0, n64 = 0;
      for (int cyc = 0; cyc < 1015; cyc++) begin
         sw_valid = (cyc < 1000);
         sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
         sw_cin = 1'($urandom); sw_sub = 1'($urandom);
         if (cyc % 7 == 0) sw_b = sw_a;
         #1;
         if (v81) begin
            checks++;
            e = (q81.size() != 0) ? q81.pop_front() : '1;
            t = (t81.size() != 0) ? t81.pop_front() : -100;
            n81++;
            if ({z81, o81, c81, 56'd0, s81} !== e || cyc - t != 1) begin
               errors++;
               $display("FAIL sweep_8_1: got sum=%h c=%b o=%b z=%b lat=%0d want sum=%h c=%b o=%b z=%b lat=1",
                        s81, c81, o81, z81, cyc - t, e[7:0], e[64], e[65], e[66]);
            end
         end
         if (v88) begin
            checks++;
            e = (q88.size() != 0) ? q88.pop_front() : '1;
            t = (t88.size() != 0) ? t88.pop_front() : -100;
            n88++;
            if ({z88, o88, c88, 56'd0, s88} !== e || cyc - t != 8) begin
               errors++;
               $display("FAIL sweep_8_8: got sum=%h c=%b o=%b z=%b lat=%0d want sum=%h c=%b o=%b z=%b lat=8",
                        s88, c88, o88, z88, cyc - t, e[7:0], e[64], e[65], e[66]);
            end
         end
         if (v64) begin
            checks++;
            e = (q64.size() != 0) ? q64.pop_front() : '1;
            t = (t64.size() != 0) ? t64.pop_front() : -100;
            n64++;
            if ({z64, o64, c64, s64} !== e || cyc - t != 4) begin
               errors++;
               $display("FAIL sweep_64_4: got sum=%h c=%b o=%b z=%b lat=%0d want sum=%h c=%b o=%b z=%b lat=4",
                        s64, c64, o64, z64, cyc - t, e[63:0], e[64], e[65], e[66]);
            end
         end
         if (sw_valid && r81) begin q81.push_back(model(8,  sw_a, sw_b, sw_cin, sw_sub)); t81.push_back(cyc); end
         if (sw_valid && r88) begin q88.push_back(model(8,  sw_a, sw_b, sw_cin, sw_sub)); t88.push_back(cyc); end
         if (sw_valid && r64) begin q64.push_back(model(64, sw_a, sw_b, sw_cin, sw_sub)); t64.push_back(cyc); end
         step();
      end
      sw_valid = 1'b0;
      checks++;
      if (n81 != 1000 || n88 != 1000 || n64 != 1000) begin
         errors++;
         $display("FAIL sweep_count: got %0d/%0d/%0d results want 1000 each", n81, n88, n64);
      end
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_add_sub_flags();
      test_backpressure();
      test_reset_midflight();
      test_param_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
